// File: rtl/imem_ctrl_pkg.sv
// Shared types, defaults and helpers for the instruction-memory controller.
package imem_ctrl_pkg;

  localparam int IMEM_DEPTH_DEF      = 2048;
  localparam int IMEM_STARVE_MAX_DEF = 4;

  // Data returned alongside a trapped (misaligned) fetch.
  localparam logic [31:0] IMEM_ERR_DATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } imem_state_e;

  function automatic int idx_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_ctrl_if.sv
// Fetch, loader and memory-port signals of the instruction-memory controller.
interface imem_ctrl_if
  import imem_ctrl_pkg::*;
#(
  parameter int IDX_W = idx_width(IMEM_DEPTH_DEF)
);

  logic              fetch_req_i;
  logic [31:0]       fetch_addr_i;
  logic              fetch_gnt_o;
  logic              fetch_rvalid_o;
  logic [31:0]       fetch_rdata_o;
  logic              fetch_err_o;

  logic              load_req_i;
  logic [31:0]       load_addr_i;
  logic [31:0]       load_wdata_i;
  logic              load_gnt_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [IDX_W-1:0]  mem_idx_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  // The controller side.
  modport slave (
    input  fetch_req_i, fetch_addr_i, load_req_i, load_addr_i, load_wdata_i, mem_rdata_i,
    output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o, load_gnt_o,
           mem_en_o, mem_we_o, mem_idx_o, mem_wdata_o
  );

  // The requesters plus the memory array.
  modport master (
    output fetch_req_i, fetch_addr_i, load_req_i, load_addr_i, load_wdata_i, mem_rdata_i,
    input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o, load_gnt_o,
           mem_en_o, mem_we_o, mem_idx_o, mem_wdata_o
  );

endinterface

// File: rtl/imem_arb.sv
// Fixed-priority arbiter (loader first) with a starvation counter that
// guarantees a waiting fetch is served after STARVE_MAX consecutive loads.
module imem_arb
  import imem_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = IMEM_STARVE_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic fetch_req,
  input  logic load_req,
  input  logic eligible,
  output logic fetch_gnt,
  output logic load_gnt
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q;
  logic             starved;

  assign starved = (starve_q == CNT_W'(STARVE_MAX));

  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (eligible) begin
      if (load_req && !(fetch_req && starved)) begin
        load_gnt = 1'b1;
      end else if (fetch_req) begin
        fetch_gnt = 1'b1;
      end
    end
  end

  // Counts only loads that overtook a waiting fetch; saturates at STARVE_MAX.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (!fetch_req || fetch_gnt) begin
      starve_q <= '0;
    end else if (load_gnt && !starved) begin
      starve_q <= starve_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// Shares the single synchronous instruction-memory port between fetch (read)
// and loader (write). Optional feature macro: IMEM_MISALIGN_TRAP_EN.
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter  int DEPTH      = IMEM_DEPTH_DEF,
  parameter  int STARVE_MAX = IMEM_STARVE_MAX_DEF,
  localparam int IDX_W      = idx_width(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  imem_ctrl_if.slave  bus
);

  imem_state_e      state_q;
  imem_state_e      state_d;
  logic [31:0]      rdata_q;
  logic [31:0]      read_data;
  logic             eligible;
  logic             fetch_gnt;
  logic             load_gnt;
  logic             fetch_misaligned;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] load_idx;
  logic             unused_addr_bits;

  assign fetch_idx = bus.fetch_addr_i[IDX_W+1:2];
  assign load_idx  = bus.load_addr_i[IDX_W+1:2];

  // Upper address bits wrap and the byte offset only matters for trapping.
  assign unused_addr_bits = ^{bus.fetch_addr_i[31:IDX_W+2], bus.fetch_addr_i[1:0],
                              bus.load_addr_i[31:IDX_W+2], bus.load_addr_i[1:0]};

  // Gating with reset keeps every output at zero while reset is held.
  assign eligible = rst_ni && (state_q != RD_WAIT);

  imem_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .fetch_req (bus.fetch_req_i),
    .load_req  (bus.load_req_i),
    .eligible  (eligible),
    .fetch_gnt (fetch_gnt),
    .load_gnt  (load_gnt)
  );

`ifdef IMEM_MISALIGN_TRAP_EN
  logic err_q;

  assign fetch_misaligned = |bus.fetch_addr_i[1:0];
  assign read_data        = err_q ? IMEM_ERR_DATA : bus.mem_rdata_i;
  assign bus.fetch_err_o  = (state_q == RESP) && err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (fetch_gnt) begin
      err_q <= fetch_misaligned;
    end
  end
`else
  assign fetch_misaligned = 1'b0;
  assign read_data        = bus.mem_rdata_i;
  assign bus.fetch_err_o  = 1'b0;
`endif

  assign bus.fetch_gnt_o    = fetch_gnt;
  assign bus.load_gnt_o     = load_gnt;
  assign bus.fetch_rvalid_o = (state_q == RESP);
  assign bus.fetch_rdata_o  = rdata_q;

  always_comb begin
    state_d         = state_q;
    bus.mem_en_o    = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_idx_o   = '0;
    bus.mem_wdata_o = '0;

    if (load_gnt) begin
      bus.mem_en_o    = 1'b1;
      bus.mem_we_o    = 1'b1;
      bus.mem_idx_o   = load_idx;
      bus.mem_wdata_o = bus.load_wdata_i;
    end else if (fetch_gnt) begin
      bus.mem_en_o  = !fetch_misaligned;
      bus.mem_idx_o = fetch_idx;
    end

    case (state_q)
      IDLE:    if (fetch_gnt) state_d = RD_WAIT;
      RD_WAIT: state_d = RESP;
      RESP:    state_d = fetch_gnt ? RD_WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The read result is captured the cycle after the read enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RD_WAIT) begin
        rdata_q <= read_data;
      end
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Randomized self-checking bench for imem_ctrl against a cycle-level reference
// model; follows IMEM_MISALIGN_TRAP_EN when defined.
module tb_imem_ctrl;
  import imem_ctrl_pkg::*;

  localparam int DEPTH      = 2048;
  localparam int STARVE_MAX = 4;
  localparam int IDX_W      = idx_width(DEPTH);
  localparam int VW         = 70 + IDX_W;

  typedef struct packed {
    int          due;
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic clk;
  logic rst_n;
  logic mem_ready = 1'b0;

  logic [31:0] mem_arr [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  resp_t       rq [$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        in_reset, hold;
  logic        f_req, l_req;
  logic [31:0] f_addr, l_addr, l_data;

  logic        m_busy;
  int          m_starve;

  logic             e_fg, e_lg, e_rv, e_err, e_en;
  logic [31:0]      e_rd;
  logic [IDX_W-1:0] e_idx;
  logic [VW-1:0]    exp_vec;

  imem_ctrl_if #(.IDX_W(IDX_W)) bus ();

  imem_ctrl #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'h0000_0013 : (32'h1000_0000 ^ (32'(i) * 32'h9E37_79B9));
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] a);
    return a[IDX_W+1:2];
  endfunction

  // Synchronous single-port memory array driven by the controller.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < DEPTH; i++) mem_arr[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (bus.mem_en_o) begin
      if (bus.mem_we_o) mem_arr[bus.mem_idx_o] <= bus.mem_wdata_o;
      else              bus.mem_rdata_i <= mem_arr[bus.mem_idx_o];
    end
  end

  function automatic logic [VW-1:0] act_vec();
    return {bus.fetch_gnt_o, bus.load_gnt_o, bus.fetch_rvalid_o, bus.fetch_err_o,
            bus.fetch_rvalid_o ? bus.fetch_rdata_o : 32'h0,
            bus.mem_en_o, bus.mem_we_o,
            bus.mem_en_o ? bus.mem_idx_o : {IDX_W{1'b0}},
            bus.mem_we_o ? bus.mem_wdata_o : 32'h0};
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = (32'($urandom_range(0, 3)) << (IDX_W + 2)) | (32'($urandom_range(0, 15)) << 2);
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  // One clock cycle: drive intents, predict this cycle's outputs, advance the model.
  task automatic tick();
    logic  mis;
    resp_t r;
    @(posedge clk);
    #1;
    cyc++;
    rst_n            = !in_reset;
    bus.fetch_req_i  = f_req;
    bus.fetch_addr_i = f_addr;
    bus.load_req_i   = l_req;
    bus.load_addr_i  = l_addr;
    bus.load_wdata_i = l_data;
    e_fg = 1'b0; e_lg = 1'b0; e_rv = 1'b0; e_err = 1'b0; e_rd = 32'h0;
    mis = 1'b0;
`ifdef IMEM_MISALIGN_TRAP_EN
    mis = (f_addr[1:0] != 2'b00);
`endif
    if (in_reset) begin
      rq.delete();
      m_busy   = 1'b0;
      m_starve = 0;
    end else begin
      if (!m_busy) begin
        if (f_req && l_req && m_starve == STARVE_MAX) e_fg = 1'b1;
        else if (l_req)                                e_lg = 1'b1;
        else if (f_req)                                e_fg = 1'b1;
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r     = rq.pop_front();
        e_rv  = 1'b1;
        e_rd  = r.data;
        e_err = r.err;
      end
      if (e_lg) ref_mem[idx_of(l_addr)] = l_data;
      if (e_fg) begin
        r.due  = cyc + 2;
        r.data = mis ? 32'h0 : ref_mem[idx_of(f_addr)];
        r.err  = mis;
        rq.push_back(r);
      end
      if (!f_req || e_fg)                     m_starve = 0;
      else if (e_lg && m_starve < STARVE_MAX) m_starve++;
      m_busy = e_fg;
    end
    e_en  = e_lg || (e_fg && !mis);
    e_idx = e_lg ? idx_of(l_addr) : idx_of(f_addr);
    exp_vec = {e_fg, e_lg, e_rv, e_err, e_rv ? e_rd : 32'h0, e_en, e_lg,
               e_en ? e_idx : {IDX_W{1'b0}}, e_lg ? l_data : 32'h0};
    if (!hold) begin
      if (e_fg) f_req = 1'b0;
      if (e_lg) l_req = 1'b0;
    end
    #3;
  endtask

  task automatic test_reset();
    int  gcyc;
    bit  seen;
    in_reset = 1'b1; f_req = 1'b0; l_req = 1'b0;
    repeat (3) tick();
    total++;
    if ({bus.fetch_gnt_o, bus.load_gnt_o, bus.fetch_rvalid_o, bus.fetch_rdata_o, bus.fetch_err_o,
         bus.mem_en_o, bus.mem_we_o, bus.mem_idx_o, bus.mem_wdata_o} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got rdata=%h en=%b gnt=%b/%b rv=%b", bus.fetch_rdata_o,
               bus.mem_en_o, bus.fetch_gnt_o, bus.load_gnt_o, bus.fetch_rvalid_o);
    end
    in_reset = 1'b0;
    f_req = 1'b1; f_addr = 32'h0000_0008;
    gcyc = -100; seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (act_vec() !== exp_vec) begin
        bad++; $display("[TB] FAIL first_fetch cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
      if (bus.fetch_gnt_o) begin
        gcyc = cyc;
        total++;
        if (bus.mem_idx_o !== IDX_W'(2)) begin
          bad++; $display("[TB] FAIL first_fetch_idx got=%0d exp=2", bus.mem_idx_o);
        end
      end
      if (bus.fetch_rvalid_o) begin
        seen = 1'b1;
        total++;
        if (cyc - gcyc != 2 || bus.fetch_rdata_o !== 32'h0000_0013) begin
          bad++; $display("[TB] FAIL first_fetch_resp lat=%0d data=%h exp lat=2 data=00000013",
                          cyc - gcyc, bus.fetch_rdata_o);
        end
      end
    end
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL first_fetch_timeout got no rvalid exp rvalid"); end
  endtask

  task automatic test_load_then_fetch();
    bit seen;
    l_req = 1'b1; l_addr = 32'h0000_0004; l_data = 32'hDEAD_BEEF;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (act_vec() !== exp_vec) begin
        bad++; $display("[TB] FAIL load cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
      if (bus.load_gnt_o) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL load_timeout got no grant exp grant"); end
    for (int k = 0; k < 2; k++) begin
      f_req = 1'b1; f_addr = (k == 0) ? 32'h0000_0004 : 32'h0000_2004;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        total++;
        if (act_vec() !== exp_vec) begin
          bad++; $display("[TB] FAIL load_fetch cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
        end
        if (bus.fetch_rvalid_o) begin
          seen = 1'b1;
          total++;
          if (bus.fetch_rdata_o !== 32'hDEAD_BEEF) begin
            bad++; $display("[TB] FAIL load_fetch_data addr=%h got=%h exp=deadbeef", f_addr, bus.fetch_rdata_o);
          end
        end
      end
      total++;
      if (!seen) begin bad++; $display("[TB] FAIL load_fetch_timeout got no rvalid exp rvalid"); end
    end
  endtask

  task automatic test_starvation();
    int loads_run, fcount;
    loads_run = 0; fcount = 0;
    hold = 1'b1;
    f_req = 1'b1; f_addr = 32'h0000_0010;
    l_req = 1'b1; l_addr = 32'h0000_0040; l_data = $urandom;
    for (int i = 0; i < 24; i++) begin
      tick();
      l_data = $urandom;
      total++;
      if (act_vec() !== exp_vec) begin
        bad++; $display("[TB] FAIL starve cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
      total++;
      if (bus.fetch_gnt_o && bus.load_gnt_o) begin
        bad++; $display("[TB] FAIL starve_both cyc=%0d got both grants exp at most one", cyc);
      end
      if (bus.load_gnt_o) loads_run++;
      if (bus.fetch_gnt_o) begin
        fcount++;
        total++;
        if (loads_run != STARVE_MAX) begin
          bad++; $display("[TB] FAIL starve_run got=%0d loads exp=%0d", loads_run, STARVE_MAX);
        end
        loads_run = 0;
      end
    end
    total++;
    if (fcount != 4) begin bad++; $display("[TB] FAIL starve_fetches got=%0d exp=4", fcount); end
    hold = 1'b0; f_req = 1'b0; l_req = 1'b0;
    repeat (3) begin
      tick();
      total++;
      if (act_vec() !== exp_vec) begin
        bad++; $display("[TB] FAIL starve_drain cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end
  endtask

  task automatic test_back_to_back();
    int g[$];
    int rv[$];
    int n;
    n = 1;
    f_req = 1'b1; f_addr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (e_fg && n < 3) begin f_req = 1'b1; f_addr = 32'(n * 4); n++; end
      total++;
      if (act_vec() !== exp_vec) begin
        bad++; $display("[TB] FAIL b2b cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
      if (bus.fetch_gnt_o) g.push_back(cyc);
      if (bus.fetch_rvalid_o) rv.push_back(cyc);
    end
    total++;
    if (g.size() != 3 || rv.size() != 3) begin
      bad++; $display("[TB] FAIL b2b_count got grants=%0d rvalids=%0d exp 3/3", g.size(), rv.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (g[k] - g[0] != 2 * k || rv[k] - g[k] != 2) begin
          bad++; $display("[TB] FAIL b2b_timing k=%0d got gnt_off=%0d lat=%0d exp %0d/2",
                          k, g[k] - g[0], rv[k] - g[k], 2 * k);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    f_req = 1'b1; f_addr = 32'h0000_000C;
    tick();
    total++;
    if (act_vec() !== exp_vec) begin
      bad++; $display("[TB] FAIL rst_mid_grant cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
    end
    in_reset = 1'b1;
    repeat (2) tick();
    in_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (bus.fetch_rvalid_o !== 1'b0 || act_vec() !== exp_vec) begin
        bad++; $display("[TB] FAIL rst_mid_rvalid cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end
    f_req = 1'b1; f_addr = 32'h0000_0010;
    tick();
    total++;
    if (bus.fetch_gnt_o !== 1'b1) begin
      bad++; $display("[TB] FAIL rst_mid_idle got gnt=%b exp gnt=1", bus.fetch_gnt_o);
    end
    repeat (3) begin
      tick();
      total++;
      if (act_vec() !== exp_vec) begin
        bad++; $display("[TB] FAIL rst_mid_drain cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end
  endtask

  task automatic test_misaligned();
    bit seen;
    seen = 1'b0;
    f_req = 1'b1; f_addr = 32'h0000_0006;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (act_vec() !== exp_vec) begin
        bad++; $display("[TB] FAIL misalign cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
      if (bus.fetch_gnt_o) begin
        total++;
`ifdef IMEM_MISALIGN_TRAP_EN
        if (bus.mem_en_o !== 1'b0) begin
          bad++; $display("[TB] FAIL misalign_en got=%b exp=0", bus.mem_en_o);
        end
`else
        if (bus.mem_en_o !== 1'b1 || bus.mem_idx_o !== IDX_W'(1)) begin
          bad++; $display("[TB] FAIL misalign_en got en=%b idx=%0d exp en=1 idx=1", bus.mem_en_o, bus.mem_idx_o);
        end
`endif
      end
      if (bus.fetch_rvalid_o) begin
        seen = 1'b1;
        total++;
`ifdef IMEM_MISALIGN_TRAP_EN
        if (bus.fetch_err_o !== 1'b1 || bus.fetch_rdata_o !== 32'h0) begin
          bad++; $display("[TB] FAIL misalign_resp got err=%b data=%h exp err=1 data=0",
                          bus.fetch_err_o, bus.fetch_rdata_o);
        end
`else
        if (bus.fetch_err_o !== 1'b0 || bus.fetch_rdata_o !== 32'hDEAD_BEEF) begin
          bad++; $display("[TB] FAIL misalign_resp got err=%b data=%h exp err=0 data=deadbeef",
                          bus.fetch_err_o, bus.fetch_rdata_o);
        end
`endif
      end
    end
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL misalign_timeout got no rvalid exp rvalid"); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!f_req && $urandom_range(0, 2) == 0) begin f_req = 1'b1; f_addr = rand_addr(); end
      if (!l_req && $urandom_range(0, 1) == 0) begin
        l_req = 1'b1; l_addr = rand_addr(); l_data = $urandom;
      end
      tick();
      total++;
      if (act_vec() !== exp_vec) begin
        bad++; $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end
    f_req = 1'b0; l_req = 1'b0;
    repeat (4) begin
      tick();
      total++;
      if (act_vec() !== exp_vec) begin
        bad++; $display("[TB] FAIL random_drain cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    in_reset = 1'b1; hold = 1'b0;
    f_req = 1'b0; l_req = 1'b0;
    f_addr = 32'h0; l_addr = 32'h0; l_data = 32'h0;
    m_busy = 1'b0; m_starve = 0;
    bus.fetch_req_i = 1'b0; bus.fetch_addr_i = 32'h0;
    bus.load_req_i = 1'b0; bus.load_addr_i = 32'h0; bus.load_wdata_i = 32'h0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    #2 rst_n = 1'b0;
    test_reset();
    test_load_then_fetch();
    test_starvation();
    test_back_to_back();
    test_reset_mid_read();
    test_misaligned();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
